// File: rtl/cpu_pkg.sv
// Shared CPU types: register index, datapath word and the default load-tag depth.
package cpu_pkg;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] xlen_t;

  localparam int unsigned LD_DEPTH_DEF = 4;

endpackage

// File: rtl/writeback_checker.sv
// Simulation-only protocol monitor for the writeback load-tag interface.
module writeback_checker (
  input logic clk,
  input logic reset,
  input logic en,
  input logic ld_issue,
  input logic ld_full,
  input logic mem_valid,
  input logic fifo_empty
);

  // Flag issuer/memory protocol violations; the datapath itself drops them.
  always_ff @(posedge clk) begin
    if (!reset && en) begin
      if (ld_issue && ld_full && !mem_valid) begin
        $error("writeback: load issued while tag FIFO full, push dropped");
      end else begin
      end
      if (mem_valid && fifo_empty) begin
        $error("writeback: load response with no outstanding load, dropped");
      end else begin
      end
    end else begin
    end
  end

endmodule

// File: rtl/writeback_tag_fifo.sv
// In-order tag FIFO holding the destination register of every outstanding load.
module tag_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = LD_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  reg_idx_t           push_rd,
  output reg_idx_t           head_rd,
  output logic               full,
  output logic               empty,
  output logic [DEPTH*5-1:0] entries,
  output logic [DEPTH-1:0]   entry_valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  reg_idx_t        mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            push_ok_s;
  logic            pop_ok_s;
  logic [PW-1:0]   off_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign pop_ok_s  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push while full is still taken.
  assign push_ok_s = push & (~full | pop_ok_s);
  assign head_rd   = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= 5'd0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_rd;
        wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    entry_valid = {DEPTH{1'b0}};
    entries     = {(DEPTH*5){1'b0}};
    off_s       = {PW{1'b0}};
    for (int i = 0; i < int'(DEPTH); i++) begin
      off_s            = PW'(i) - rd_ptr_r;
      entry_valid[i]   = ({1'b0, off_s} < count_r);
      entries[i*5 +: 5] = mem_r[i];
    end
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: owns the regfile write port, arbitrates load responses over
// execute results and stalls decode on registers with a load in flight.
module writeback
  import cpu_pkg::*;
#(
  parameter int unsigned LD_DEPTH = LD_DEPTH_DEF
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     ex_valid,
  input  reg_idx_t ex_rd,
  input  xlen_t    ex_data,
  output logic     ex_ready,
  input  logic     ld_issue,
  input  reg_idx_t ld_rd,
  output logic     ld_full,
  input  logic     mem_valid,
  input  xlen_t    mem_data,
  input  reg_idx_t chk_rs1,
  input  reg_idx_t chk_rs2,
  input  reg_idx_t chk_rd,
  output logic     stall,
  output reg_idx_t wreg,
  output xlen_t    wdata,
  output logic     wen
);

  reg_idx_t                head_rd_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [LD_DEPTH*5-1:0]   entries_s;
  logic [LD_DEPTH-1:0]     entry_valid_s;
  logic                    mem_take_s;
  logic                    sel_take_s;
  reg_idx_t                sel_rd_s;
  xlen_t                   sel_data_s;
  logic                    sel_wen_s;
  logic                    hit_s;
  reg_idx_t                ent_s;

  tag_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (ld_issue),
    .pop         (mem_valid),
    .push_rd     (ld_rd),
    .head_rd     (head_rd_s),
    .full        (fifo_full_s),
    .empty       (fifo_empty_s),
    .entries     (entries_s),
    .entry_valid (entry_valid_s)
  );

  assign ex_ready   = ~mem_valid;
  assign ld_full    = fifo_full_s;
  assign mem_take_s = mem_valid & ~fifo_empty_s;
  assign sel_wen_s  = sel_take_s & (sel_rd_s != 5'd0);
  assign stall      = hit_s;

  // Source select: a load response always wins over an execute result.
  always_comb begin
    sel_take_s = 1'b0;
    sel_rd_s   = 5'd0;
    sel_data_s = 32'd0;
    if (mem_take_s) begin
      sel_take_s = 1'b1;
      sel_rd_s   = head_rd_s;
      sel_data_s = mem_data;
    end else if (ex_valid && ex_ready) begin
      sel_take_s = 1'b1;
      sel_rd_s   = ex_rd;
      sel_data_s = ex_data;
    end else begin
      sel_take_s = 1'b0;
    end
  end

  // Hazard compare of decode operands against every live load tag; x0 never matches.
  always_comb begin
    hit_s = 1'b0;
    ent_s = 5'd0;
    for (int i = 0; i < int'(LD_DEPTH); i++) begin
      ent_s = entries_s[i*5 +: 5];
      hit_s = hit_s | (entry_valid_s[i] & (ent_s != 5'd0) &
                       ((ent_s == chk_rs1) | (ent_s == chk_rs2) | (ent_s == chk_rd)));
    end
  end

  // Registered regfile write port; wen is a one-cycle pulse per accepted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wen   <= 1'b0;
      wreg  <= 5'd0;
      wdata <= 32'd0;
    end else begin
      wen <= sel_wen_s;
      if (sel_take_s) begin
        wreg  <= sel_rd_s;
        wdata <= sel_data_s;
      end else begin
        wreg  <= wreg;
        wdata <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Directed and randomized self-checking bench for writeback, with a queue model of outstanding loads.
module tb_writeback;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ex_ready;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic        ld_full;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic [4:0]  chk_rs1, chk_rs2, chk_rd;
  logic        stall;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        wen;
  logic        chk_en;

  int total = 0;
  int bad   = 0;

  writeback #(.LD_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_full(ld_full),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .stall(stall), .wreg(wreg), .wdata(wdata), .wen(wen)
  );

  writeback_checker u_chk (
    .clk(clk), .reset(reset), .en(chk_en),
    .ld_issue(ld_issue), .ld_full(ld_full), .mem_valid(mem_valid),
    .fifo_empty(dut.fifo_empty_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_rd = 5'd0; ex_data = 32'd0;
    ld_issue = 1'b0; ld_rd = 5'd0;
    mem_valid = 1'b0; mem_data = 32'd0;
    chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;
  endtask

  logic [4:0]  q[$];
  logic [4:0]  drain_exp [4];
  logic        ex_hold;
  logic        e_take, e_stall;
  logic [4:0]  e_rd;
  logic [31:0] e_data;

  initial begin
    chk_en = 1'b1;
    idle();
    // Reset held two cycles with an execute result present.
    reset = 1'b1; ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'h1111_1111;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_wen", wen, 1'b0); chk("rst_wreg", wreg, 5'd0); chk("rst_wdata", wdata, 32'd0);
      chk("rst_ld_full", ld_full, 1'b0); chk("rst_stall", stall, 1'b0);
    end
    reset = 1'b0; idle();
    tick();

    // Execute write, then execute write to x0.
    ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEAD_BEEF; #1;
    chk("ex_ready", ex_ready, 1'b1);
    tick(); ex_valid = 1'b0;
    chk("ex_wen", wen, 1'b1); chk("ex_wreg", wreg, 5'd5); chk("ex_wdata", wdata, 32'hDEAD_BEEF);
    tick();
    chk("ex_wen_pulse", wen, 1'b0);
    ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'h5555_AAAA; #1;
    chk("ex0_ready", ex_ready, 1'b1);
    tick(); ex_valid = 1'b0;
    chk("ex0_wen", wen, 1'b0);

    // Load hazard on rs2.
    ld_issue = 1'b1; ld_rd = 5'd7;
    tick(); ld_issue = 1'b0; chk_rs2 = 5'd7; #1;
    chk("hz_stall", stall, 1'b1);
    mem_valid = 1'b1; mem_data = 32'h1234_5678; #1;
    chk("hz_stall_pop_cycle", stall, 1'b1);
    tick(); mem_valid = 1'b0; #1;
    chk("hz_stall_clear", stall, 1'b0); chk("hz_wen", wen, 1'b1);
    chk("hz_wreg", wreg, 5'd7); chk("hz_wdata", wdata, 32'h1234_5678);
    chk_rs2 = 5'd0;

    // Collision: load response beats execute result.
    ld_issue = 1'b1; ld_rd = 5'd3;
    tick(); ld_issue = 1'b0;
    mem_valid = 1'b1; mem_data = 32'hAAAA_0003;
    ex_valid = 1'b1; ex_rd = 5'd4; ex_data = 32'hBBBB_0004; #1;
    chk("col_ex_ready", ex_ready, 1'b0);
    tick(); mem_valid = 1'b0; #1;
    chk("col_w1_reg", wreg, 5'd3); chk("col_w1_data", wdata, 32'hAAAA_0003); chk("col_w1_wen", wen, 1'b1);
    chk("col_ex_ready2", ex_ready, 1'b1);
    tick(); ex_valid = 1'b0;
    chk("col_w2_reg", wreg, 5'd4); chk("col_w2_data", wdata, 32'hBBBB_0004); chk("col_w2_wen", wen, 1'b1);
    tick();
    chk("col_idle_wen", wen, 1'b0);

    // Fill, dropped overflow push, push+pop while full, drain.
    for (int k = 1; k <= 4; k++) begin
      ld_issue = 1'b1; ld_rd = 5'(k);
      tick();
    end
    ld_issue = 1'b0; #1;
    chk("fill_full", ld_full, 1'b1);
    chk_en = 1'b0;
    ld_issue = 1'b1; ld_rd = 5'd8;
    tick(); ld_issue = 1'b0;
    chk_en = 1'b1;
    chk_rd = 5'd8; #1;
    chk("drop_no_stall", stall, 1'b0);
    chk("drop_full", ld_full, 1'b1);
    chk_rd = 5'd0;
    ld_issue = 1'b1; ld_rd = 5'd9; mem_valid = 1'b1; mem_data = 32'h0000_0100;
    tick(); ld_issue = 1'b0;
    chk("pp_wreg", wreg, 5'd1); chk("pp_wen", wen, 1'b1); chk("pp_full", ld_full, 1'b1);
    drain_exp = '{5'd2, 5'd3, 5'd4, 5'd9};
    for (int k = 0; k < 4; k++) begin
      mem_valid = 1'b1; mem_data = 32'h0000_0200 + 32'(k);
      tick();
      chk("drain_wreg", wreg, drain_exp[k]);
      chk("drain_wdata", wdata, 32'h0000_0200 + 32'(k));
      chk("drain_wen", wen, 1'b1);
    end
    mem_valid = 1'b0; #1;
    chk("drain_not_full", ld_full, 1'b0);

    // Duplicate destination: stall persists until the second response.
    ld_issue = 1'b1; ld_rd = 5'd6; tick();
    tick(); ld_issue = 1'b0;
    chk_rd = 5'd6; #1;
    chk("dup_stall0", stall, 1'b1);
    mem_valid = 1'b1; mem_data = 32'h6; tick(); mem_valid = 1'b0; #1;
    chk("dup_stall1", stall, 1'b1);
    mem_valid = 1'b1; tick(); mem_valid = 1'b0; #1;
    chk("dup_stall2", stall, 1'b0);
    chk_rd = 5'd0;

    // Reset with three loads outstanding and a response in flight.
    for (int k = 10; k <= 12; k++) begin
      ld_issue = 1'b1; ld_rd = 5'(k); tick();
    end
    ld_issue = 1'b0; chk_rs1 = 5'd11; #1;
    chk("rmid_stall_before", stall, 1'b1);
    reset = 1'b1; mem_valid = 1'b1; mem_data = 32'hFFFF_FFFF;
    tick(); reset = 1'b0; mem_valid = 1'b0; #1;
    chk("rmid_stall", stall, 1'b0); chk("rmid_wen", wen, 1'b0); chk("rmid_full", ld_full, 1'b0);
    idle();
    tick();

    // Randomized traffic against a queue model of outstanding load tags.
    q.delete();
    ex_hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      mem_valid = (q.size() > 0) && ($urandom_range(0, 99) < 40);
      mem_data  = $urandom();
      if (!ex_hold) begin
        ex_valid = ($urandom_range(0, 99) < 50);
        ex_rd    = 5'($urandom_range(0, 7));
        ex_data  = $urandom();
      end
      ld_issue = ((q.size() < 4) || mem_valid) && ($urandom_range(0, 99) < 45);
      ld_rd    = 5'($urandom_range(0, 7));
      chk_rs1  = 5'($urandom_range(0, 7));
      chk_rs2  = 5'($urandom_range(0, 7));
      chk_rd   = 5'($urandom_range(0, 7));
      #1;
      e_stall = 1'b0;
      foreach (q[k]) begin
        if (q[k] != 5'd0 && (q[k] == chk_rs1 || q[k] == chk_rs2 || q[k] == chk_rd)) e_stall = 1'b1;
      end
      chk("rnd_stall", stall, e_stall);
      chk("rnd_ex_ready", ex_ready, !mem_valid);
      chk("rnd_ld_full", ld_full, q.size() == 4);
      e_take = 1'b0; e_rd = 5'd0; e_data = 32'd0;
      if (mem_valid) begin
        e_take = 1'b1; e_rd = q[0]; e_data = mem_data;
      end else if (ex_valid) begin
        e_take = 1'b1; e_rd = ex_rd; e_data = ex_data;
      end
      ex_hold = ex_valid && mem_valid;
      tick();
      if (mem_valid) void'(q.pop_front());
      if (ld_issue) q.push_back(ld_rd);
      chk("rnd_wen", wen, e_take && (e_rd != 5'd0));
      if (e_take && (e_rd != 5'd0)) begin
        chk("rnd_wreg", wreg, e_rd);
        chk("rnd_wdata", wdata, e_data);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
